// File: rtl/addr_bus_if.sv
// Bus bundle between the control side and the addr_bus datapath: stall qualifier,
// AB mode, operand bytes, and the registered address/PC/status outputs.
interface addr_bus_if;
  // rdy is a pure stall qualifier, not a handshake: when low, the datapath ignores
  // every other input and holds all state. When high, one mode executes per clock.
  logic        rdy;
  logic [3:0]  mode;
  logic [7:0]  DB;
  logic [7:0]  REG;
  logic [7:0]  SP;
  logic [7:0]  VEC;
  logic        cond;
  logic [15:0] AB;
  logic [15:0] PC;
  logic [7:0]  AHL;
  logic        bad_mode;

  modport master (
    output rdy, mode, DB, REG, SP, VEC, cond,
    input  AB, PC, AHL, bad_mode
  );

  modport slave (
    input  rdy, mode, DB, REG, SP, VEC, cond,
    output AB, PC, AHL, bad_mode
  );
endinterface

// File: rtl/addr_bus.sv
// 65C02 address-bus datapath: registers AB, PC and the low-address latch AHL,
// and steps them each cycle according to the AB mode from the control FSM.
module addr_bus #(
    parameter logic [15:0] RESET_AB = 16'h0000,
    parameter logic [7:0]  VEC_PAGE = 8'hFF
) (
    input logic       clk,
    input logic       reset_n,
    addr_bus_if.slave bus
);

    localparam logic [3:0] M_LATCH    = 4'b0000;
    localparam logic [3:0] M_PC       = 4'b0001;
    localparam logic [3:0] M_ABS_IDX  = 4'b0010;
    localparam logic [3:0] M_ZP_IDX   = 4'b0011;
    localparam logic [3:0] M_INC      = 4'b0100;
    localparam logic [3:0] M_POP      = 4'b0101;
    localparam logic [3:0] M_BAD_A    = 4'b0110;
    localparam logic [3:0] M_BRANCH   = 4'b0111;
    localparam logic [3:0] M_STACK    = 4'b1000;
    localparam logic [3:0] M_PUSH_INC = 4'b1001;
    localparam logic [3:0] M_JUMP_IDX = 4'b1010;
    localparam logic [3:0] M_PUSH_AB  = 4'b1011;
    localparam logic [3:0] M_INC_LAT  = 4'b1100;
    localparam logic [3:0] M_BAD_B    = 4'b1101;
    localparam logic [3:0] M_IDX_INC  = 4'b1110;
    localparam logic [3:0] M_VECTOR   = 4'b1111;

    logic [15:0] ab_q, pc_q;
    logic [7:0]  ahl_q;
    logic        bad_q;

    logic [15:0] ab_next, pc_next;
    logic [7:0]  ahl_next;
    logic        bad_hit;

    logic [15:0] ab_inc;
    logic [15:0] abs_idx;
    logic [15:0] abs_idx_inc;
    logic [7:0]  zp_lo;
    logic [7:0]  sp_inc;
    logic [15:0] branch_tgt;
    logic [15:0] vec_addr;

    // All candidate addresses are computed from pre-update state, so PC and AB
    // can both move on the same edge without ordering concerns.
    always_comb begin
        ab_inc      = ab_q + 16'd1;
        abs_idx     = {bus.DB, ahl_q} + {8'h00, bus.REG};
        abs_idx_inc = {bus.DB, ahl_q} + {8'h00, bus.REG} + 16'd1;
        zp_lo       = bus.DB + bus.REG;
        sp_inc      = bus.SP + 8'd1;
        branch_tgt  = ab_q + {{8{bus.DB[7]}}, bus.DB} + 16'd1;
        vec_addr    = {VEC_PAGE, bus.VEC} + 16'd1;
    end

    always_comb begin
        ab_next  = ab_q;
        pc_next  = pc_q;
        ahl_next = ahl_q;
        bad_hit  = 1'b0;
        case (bus.mode)
            M_LATCH: begin
                ahl_next = bus.DB;
            end
            M_PC: begin
                ab_next = pc_q;
            end
            M_ABS_IDX: begin
                pc_next  = ab_inc;
                ahl_next = bus.DB;
                ab_next  = abs_idx;
            end
            M_ZP_IDX: begin
                pc_next  = ab_inc;
                ahl_next = bus.DB;
                ab_next  = {8'h00, zp_lo};
            end
            M_INC: begin
                pc_next  = ab_q;
                ahl_next = bus.DB;
                ab_next  = ab_inc;
            end
            M_POP: begin
                pc_next  = ab_q;
                ahl_next = bus.DB;
                ab_next  = {8'h01, sp_inc};
            end
            M_BRANCH: begin
                pc_next  = ab_q;
                ahl_next = bus.DB;
                ab_next  = bus.cond ? branch_tgt : ab_inc;
            end
            M_STACK: begin
                ab_next = {8'h01, bus.SP};
            end
            M_PUSH_INC: begin
                pc_next  = ab_inc;
                ahl_next = bus.DB;
                ab_next  = {8'h01, bus.SP};
            end
            M_JUMP_IDX: begin
                ahl_next = bus.DB;
                ab_next  = abs_idx;
            end
            M_PUSH_AB: begin
                pc_next = ab_q;
                ab_next = {8'h01, bus.SP};
            end
            M_INC_LAT: begin
                ahl_next = bus.DB;
                ab_next  = ab_inc;
            end
            M_IDX_INC: begin
                ahl_next = bus.DB;
                ab_next  = abs_idx_inc;
            end
            M_VECTOR: begin
                ab_next = vec_addr;
            end
            M_BAD_A, M_BAD_B: begin
                bad_hit = 1'b1;
            end
            default: begin
                bad_hit = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ab_q  <= RESET_AB;
            pc_q  <= RESET_AB;
            ahl_q <= 8'h00;
            bad_q <= 1'b0;
        end else if (bus.rdy) begin
            ab_q  <= ab_next;
            pc_q  <= pc_next;
            ahl_q <= ahl_next;
            if (bad_hit) begin
                bad_q <= 1'b1;
            end
        end
    end

    assign bus.AB       = ab_q;
    assign bus.PC       = pc_q;
    assign bus.AHL      = ahl_q;
    assign bus.bad_mode = bad_q;

endmodule

// File: tb/tb_addr_bus.sv
// Directed bench for addr_bus: hand-computed AB/PC/AHL/bad_mode after each step,
// including page crossing, zero-page and stack wrap, branches, stalls and resets.
module tb_addr_bus;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    addr_bus_if bus ();

    addr_bus #(
        .RESET_AB(16'h0000),
        .VEC_PAGE(8'hFF)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [15:0] ab, input logic [15:0] pc,
                           input logic [7:0] ahl, input logic bad);
        chk({tag, ".AB"}, bus.AB, ab);
        chk({tag, ".PC"}, bus.PC, pc);
        chk({tag, ".AHL"}, {8'h00, bus.AHL}, {8'h00, ahl});
        chk({tag, ".bad"}, {15'h0, bus.bad_mode}, {15'h0, bad});
    endtask

    // Drive one cycle's inputs, clock once, then settle 1 ns past the edge.
    task automatic cyc(input logic [3:0] m, input logic [7:0] db, input logic [7:0] rg,
                       input logic [7:0] sp, input logic [7:0] vec, input logic c,
                       input logic r);
        bus.mode = m;
        bus.DB   = db;
        bus.REG  = rg;
        bus.SP   = sp;
        bus.VEC  = vec;
        bus.cond = c;
        bus.rdy  = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        bus.rdy  = 1'b1;
        bus.mode = 4'b0100;
        bus.DB   = 8'($urandom_range(0, 255));
        bus.REG  = 8'($urandom_range(0, 255));
        bus.SP   = 8'($urandom_range(0, 255));
        bus.VEC  = 8'hFC;
        bus.cond = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_all("reset", 16'h0000, 16'h0000, 8'h00, 1'b0);
        reset_n = 1'b1;

        cyc(4'b0000, 8'hF0, 8'h00, 8'h00, 8'hFC, 1'b0, 1'b1);
        chk_all("latch_f0", 16'h0000, 16'h0000, 8'hF0, 1'b0);
        cyc(4'b0100, 8'hF0, 8'h00, 8'h00, 8'hFC, 1'b0, 1'b1);
        chk_all("inc", 16'h0001, 16'h0000, 8'hF0, 1'b0);
        cyc(4'b0010, 8'h12, 8'h20, 8'h00, 8'hFC, 1'b0, 1'b1);
        chk_all("page_cross", 16'h1310, 16'h0002, 8'h12, 1'b0);
        cyc(4'b0011, 8'hF0, 8'h20, 8'h00, 8'hFC, 1'b0, 1'b1);
        chk_all("zp_wrap", 16'h0010, 16'h1311, 8'hF0, 1'b0);
        cyc(4'b0101, 8'hF0, 8'h00, 8'hFF, 8'hFC, 1'b0, 1'b1);
        chk_all("stack_wrap", 16'h0100, 16'h0010, 8'hF0, 1'b0);

        cyc(4'b0000, 8'h00, 8'h00, 8'h00, 8'hFC, 1'b0, 1'b1);
        cyc(4'b1010, 8'h20, 8'h00, 8'h00, 8'hFC, 1'b0, 1'b1);
        chk_all("jump_2000", 16'h2000, 16'h0010, 8'h20, 1'b0);
        cyc(4'b0111, 8'hFE, 8'h00, 8'h00, 8'hFC, 1'b1, 1'b1);
        chk_all("branch_back", 16'h1FFF, 16'h2000, 8'hFE, 1'b0);
        cyc(4'b0111, 8'hFE, 8'h00, 8'h00, 8'hFC, 1'b0, 1'b1);
        chk_all("branch_nt1", 16'h2000, 16'h1FFF, 8'hFE, 1'b0);
        cyc(4'b0111, 8'hFE, 8'h00, 8'h00, 8'hFC, 1'b0, 1'b1);
        chk_all("branch_nt2", 16'h2001, 16'h2000, 8'hFE, 1'b0);

        cyc(4'b0000, 8'hFF, 8'h00, 8'h00, 8'hFC, 1'b0, 1'b1);
        cyc(4'b1010, 8'hFF, 8'h00, 8'h00, 8'hFC, 1'b0, 1'b1);
        chk_all("jump_ffff", 16'hFFFF, 16'h2000, 8'hFF, 1'b0);
        cyc(4'b0100, 8'hFF, 8'h00, 8'h00, 8'hFC, 1'b0, 1'b1);
        chk_all("inc_wrap", 16'h0000, 16'hFFFF, 8'hFF, 1'b0);

        for (int i = 0; i < 3; i++) begin
            cyc(4'b0100, 8'h55, 8'h00, 8'h00, 8'hFC, 1'b0, 1'b0);
            chk_all("stall", 16'h0000, 16'hFFFF, 8'hFF, 1'b0);
        end
        cyc(4'b0100, 8'h55, 8'h00, 8'h00, 8'hFC, 1'b0, 1'b1);
        chk_all("stall_release", 16'h0001, 16'h0000, 8'h55, 1'b0);
        cyc(4'b0110, 8'h66, 8'h00, 8'h00, 8'hFC, 1'b0, 1'b0);
        chk_all("stall_bad", 16'h0001, 16'h0000, 8'h55, 1'b0);

        cyc(4'b0001, 8'h66, 8'h00, 8'h00, 8'hFC, 1'b0, 1'b1);
        chk_all("ab_from_pc", 16'h0000, 16'h0000, 8'h55, 1'b0);
        cyc(4'b1001, 8'h66, 8'h00, 8'h80, 8'hFC, 1'b0, 1'b1);
        chk_all("push_inc", 16'h0180, 16'h0001, 8'h66, 1'b0);
        cyc(4'b1011, 8'h77, 8'h00, 8'h81, 8'hFC, 1'b0, 1'b1);
        chk_all("push_ab", 16'h0181, 16'h0180, 8'h66, 1'b0);
        cyc(4'b1000, 8'h88, 8'h00, 8'h7F, 8'hFC, 1'b0, 1'b1);
        chk_all("stack", 16'h017F, 16'h0180, 8'h66, 1'b0);
        cyc(4'b1100, 8'h99, 8'h00, 8'h00, 8'hFC, 1'b0, 1'b1);
        chk_all("inc_latch", 16'h0180, 16'h0180, 8'h99, 1'b0);
        cyc(4'b1110, 8'h12, 8'h66, 8'h00, 8'hFC, 1'b0, 1'b1);
        chk_all("idx_inc", 16'h1300, 16'h0180, 8'h12, 1'b0);
        cyc(4'b1111, 8'h34, 8'h00, 8'h00, 8'hFC, 1'b0, 1'b1);
        chk_all("vector", 16'hFFFD, 16'h0180, 8'h12, 1'b0);

        cyc(4'b0110, 8'hAB, 8'h00, 8'h00, 8'hFC, 1'b0, 1'b1);
        chk_all("bad_0110", 16'hFFFD, 16'h0180, 8'h12, 1'b1);
        cyc(4'b0100, 8'hCD, 8'h00, 8'h00, 8'hFC, 1'b0, 1'b1);
        chk_all("bad_sticky", 16'hFFFE, 16'hFFFD, 8'hCD, 1'b1);
        cyc(4'b1101, 8'hEE, 8'h00, 8'h00, 8'hFC, 1'b0, 1'b1);
        chk_all("bad_1101", 16'hFFFE, 16'hFFFD, 8'hCD, 1'b1);

        // Assert reset between edges to show it acts without a clock.
        @(posedge clk);
        #2;
        bus.rdy  = 1'b1;
        bus.mode = 4'b0100;
        reset_n  = 1'b0;
        #1;
        chk_all("async_reset", 16'h0000, 16'h0000, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        chk_all("reset_hold", 16'h0000, 16'h0000, 8'h00, 1'b0);
        reset_n = 1'b1;
        cyc(4'b0100, 8'h42, 8'h00, 8'h00, 8'hFC, 1'b0, 1'b1);
        chk_all("post_reset", 16'h0001, 16'h0000, 8'h42, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
